// File: rtl/simd_exe_sequencer.sv
// Issue/collect sequencer for the per-lane SIMD functional units: accepts one
// instruction, strobes select-output at the class latency, and holds the captured result for write-back.
module simd_exe_sequencer #(
    parameter int NUM_LANES = 2,
    parameter int TAG_W     = 6,
    parameter int DIV_LAT   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    input  logic [1:0]              instr_lat_i,
    input  logic [TAG_W-1:0]        instr_tag_i,
    input  logic                    kill_i,
    output logic                    issue_o,
    output logic                    sel_valid_o,
    output logic [TAG_W-1:0]        sel_tag_o,
    input  logic [NUM_LANES*64-1:0] result_data_i,
    input  logic [NUM_LANES-1:0]    sat_ovf_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [NUM_LANES*64-1:0] wb_data_o,
    output logic [TAG_W-1:0]        wb_tag_o,
    output logic                    wb_sat_o,
    output logic                    busy_o,
    output logic [31:0]             retired_o
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        lat_m1;
    logic                    lat_zero;
    logic                    accept;
    logic                    capture;
    logic                    wb_hs;

    // Counter preload is latency minus one; single-cycle class bypasses WAIT entirely.
    always_comb begin
        lat_m1   = '0;
        lat_zero = 1'b0;
        unique case (instr_lat_i)
            2'd0:    lat_zero = 1'b1;
            2'd1:    lat_m1 = '0;
            2'd2:    lat_m1 = CNT_W'(1);
            default: lat_m1 = CNT_W'(DIV_LAT - 1);
        endcase
    end

    assign instr_ready_o = !rst_i && !kill_i &&
                           (state_q == S_IDLE || (state_q == S_HOLD && wb_ready_i));
    assign accept      = instr_valid_i && instr_ready_o;
    assign issue_o     = accept;
    assign sel_valid_o = (accept && lat_zero) ||
                         (state_q == S_WAIT && cnt_q == '0 && !kill_i);
    assign capture     = sel_valid_o;
    assign wb_valid_o  = (state_q == S_HOLD);
    // A write-back handshake coinciding with kill does not retire.
    assign wb_hs       = wb_valid_o && wb_ready_i && !kill_i;
    assign busy_o      = (state_q != S_IDLE);

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = lat_zero ? S_HOLD : S_WAIT;
            S_WAIT: if (cnt_q == '0) state_d = S_HOLD;
            S_HOLD: begin
                if (wb_ready_i) begin
                    if (accept) state_d = lat_zero ? S_HOLD : S_WAIT;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (kill_i) state_d = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_tag_o <= '0;
            wb_data_o <= '0;
            wb_tag_o  <= '0;
            wb_sat_o  <= 1'b0;
            retired_o <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sel_tag_o <= instr_tag_i;
                cnt_q     <= lat_m1;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Zero-latency capture happens in the accept cycle, before sel_tag_o is updated.
            if (capture) begin
                wb_data_o <= result_data_i;
                wb_tag_o  <= accept ? instr_tag_i : sel_tag_o;
                wb_sat_o  <= |sat_ovf_i;
            end
            if (wb_hs) retired_o <= retired_o + 32'd1;
        end
    end

endmodule
